// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, ACK/NACK line levels
// and the default 7-bit target address.
package i2c_pkg;

    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;
    localparam logic       ACK              = 1'b0;
    localparam logic       NACK             = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_RX_BYTE  = 4'd3,
        ST_RX_ACK   = 4'd4,
        ST_TX_LOAD  = 4'd5,
        ST_TX_BYTE  = 4'd6,
        ST_TX_ACK   = 4'd7,
        ST_IGNORE   = 4'd8
    } i2c_target_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with SCL edge and START/STOP condition detection.
// Sync flops reset to 1 (idle bus level) so that leaving reset does not fake an event.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetN,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sr;
    logic [SYNC_STAGES-1:0] sda_sr;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            scl_sr <= '1;
            sda_sr <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_in};
            sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_in};
            scl_d  <= scl_sr[SYNC_STAGES-1];
            sda_d  <= sda_sr[SYNC_STAGES-1];
        end
    end

    assign scl       = scl_sr[SYNC_STAGES-1];
    assign sda       = sda_sr[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_d;
    assign scl_fall  = ~scl & scl_d;
    // SCL must have been high on both samples so an SCL edge never looks like START/STOP
    assign start_det = scl & scl_d & sda_d & ~sda;
    assign stop_det  = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_target_slave.sv
// 7-bit-address I2C target: address match, ACK, byte receive and byte transmit.
// Optional clock stretching on empty transmit data: define I2C_TARGET_CLK_STRETCH_EN.
module i2c_target_slave #(
    parameter logic [6:0]  SLAVE_ADDR  = i2c_pkg::I2C_DEFAULT_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_hit,
    output logic       rw
);
    import i2c_pkg::*;

    i2c_target_state_t state;
    logic [7:0]        shifter;
    logic [2:0]        count;
    logic              tx_last;
    logic              sda;
    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk       (clk),
        .resetN    (resetN),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

`ifdef I2C_TARGET_CLK_STRETCH_EN
    logic stretch;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stretch <= 1'b0;
        end else if (start_det || stop_det) begin
            stretch <= 1'b0;
        end else if (state == ST_TX_LOAD && !tx_valid) begin
            stretch <= 1'b1;
        end else if (state == ST_TX_BYTE) begin
            stretch <= 1'b0;
        end
    end

    assign scl_oe = stretch;
`else
    assign scl_oe = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= ST_IDLE;
            shifter  <= '0;
            count    <= 3'd7;
            tx_last  <= 1'b0;
            sda_oe   <= 1'b0;
            addr_hit <= 1'b0;
            rw       <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_ready <= 1'b0;
            if (start_det) begin
                state    <= ST_ADDR;
                count    <= 3'd7;
                tx_last  <= 1'b0;
                sda_oe   <= 1'b0;
                addr_hit <= 1'b0;
            end else if (stop_det) begin
                state    <= ST_IDLE;
                tx_last  <= 1'b0;
                sda_oe   <= 1'b0;
                addr_hit <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: if (scl_rise) begin
                        shifter <= {shifter[6:0], sda};
                        if (count == 3'd0) begin
                            if (shifter[6:0] == SLAVE_ADDR) begin
                                rw    <= sda;
                                state <= ST_ADDR_ACK;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end else begin
                            count <= count - 3'd1;
                        end
                    end
                    // sda_oe doubles as the phase flag: first fall drives ACK, second releases it
                    ST_ADDR_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe   <= 1'b1;
                            addr_hit <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            count  <= 3'd7;
                            state  <= rw ? ST_TX_LOAD : ST_RX_BYTE;
                        end
                    end
                    ST_RX_BYTE: if (scl_rise) begin
                        shifter <= {shifter[6:0], sda};
                        if (count == 3'd0) begin
                            rx_data  <= {shifter[6:0], sda};
                            rx_valid <= 1'b1;
                            state    <= ST_RX_ACK;
                        end else begin
                            count <= count - 3'd1;
                        end
                    end
                    ST_RX_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            count  <= 3'd7;
                            state  <= ST_RX_BYTE;
                        end
                    end
                    // The fall that opened this bit slot has already passed, so the MSB goes out on load
                    ST_TX_LOAD: begin
                        count   <= 3'd7;
                        tx_last <= 1'b0;
                        if (tx_valid) begin
                            shifter  <= tx_data;
                            tx_ready <= 1'b1;
                            sda_oe   <= ~tx_data[7];
                            state    <= ST_TX_BYTE;
                        end else begin
`ifndef I2C_TARGET_CLK_STRETCH_EN
                            shifter <= '1;
                            sda_oe  <= 1'b0;
                            state   <= ST_TX_BYTE;
`endif
                        end
                    end
                    ST_TX_BYTE: begin
                        if (scl_rise) begin
                            if (count == 3'd0) begin
                                tx_last <= 1'b1;
                            end else begin
                                count <= count - 3'd1;
                            end
                        end else if (scl_fall) begin
                            if (tx_last) begin
                                tx_last <= 1'b0;
                                sda_oe  <= 1'b0;
                                state   <= ST_TX_ACK;
                            end else begin
                                sda_oe <= ~shifter[count];
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise && sda == NACK) begin
                            sda_oe <= 1'b0;
                            state  <= ST_IGNORE;
                        end else if (scl_fall) begin
                            state <= ST_TX_LOAD;
                        end
                    end
                    ST_IDLE, ST_IGNORE: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_target_slave.md
Name: i2c_target_slave

Overview:
- Responder end of the team's I2C link: a 7-bit-address target that answers our I2C master controller.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches the address, ACKs, and runs the read or write transfer.
- Receives bytes on master writes; supplies bytes from the local user side on master reads.
- Sits between the open-drain pad wrappers and a local register/FIFO client.

Parameters:
- SLAVE_ADDR, 7'h50, own 7-bit address.
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate.
- resetN  input  1  asynchronous active-low reset.
- scl_in  input  1  SCL pad input.
- sda_in  input  1  SDA pad input.
- sda_oe  output  1  1 = pull SDA low (open drain).
- scl_oe  output  1  1 = hold SCL low (clock stretch).
- tx_data  input  8  byte to return on master read.
- tx_valid  input  1  tx_data available.
- tx_ready  output  1  1-clk pulse: tx_data latched into shifter.
- rx_data  output  8  last byte written by master.
- rx_valid  output  1  1-clk pulse: rx_data updated.
- addr_hit  output  1  high from address ACK until STOP or repeated START.
- rw  output  1  R/W bit of current transaction (1 = read).

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous, active-low (resetN).
- Reset values: all outputs 0; state IDLE; shifter 0; bit count 7.
- Sampling: sync scl/sda through SYNC_STAGES flops.
  - scl_rise/scl_fall = edge of synced SCL.
  - START = synced SDA falls while SCL high; STOP = synced SDA rises while SCL high.
- States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_LOAD, TX_BYTE, TX_ACK, IGNORE.
- START from any state: go to ADDR, count=7, sda_oe=0, addr_hit=0. Repeated START is handled the same way.
- STOP from any state: go to IDLE, sda_oe=0, scl_oe=0, addr_hit=0.
- ADDR: shift sda on each scl_rise, MSB first. After the 8th bit, compare [7:1] with SLAVE_ADDR.
  - Match: latch rw=bit0 and go to ADDR_ACK.
  - No match: go to IGNORE (idle until START/STOP).
- ADDR_ACK: on the next scl_fall, set sda_oe=1 and addr_hit=1. Hold through the scl_rise. On the following scl_fall, release.
  - rw=0: go to RX_BYTE.
  - rw=1: go to TX_LOAD.
- RX_BYTE: 8 scl_rise samples, MSB first. On the 8th, update rx_data and pulse rx_valid, then go to RX_ACK.
- RX_ACK: drive ACK (sda_oe=1) from scl_fall to the next scl_fall, then return to RX_BYTE. The target always ACKs written bytes.
- TX_LOAD: when tx_valid=1, latch tx_data and pulse tx_ready, then go to TX_BYTE.
  - If tx_valid=0, byte 0xFF is sent; this is the no-stretch fallback.
- TX_BYTE: bit[count] drives SDA on each scl_fall (sda_oe = ~bit). count decrements on scl_rise. After bit 0, on scl_fall, release SDA and go to TX_ACK.
- TX_ACK: sample SDA at scl_rise.
  - 0 (ACK): on scl_fall go to TX_LOAD.
  - 1 (NACK): go to IGNORE, sda_oe=0, until STOP/START.
- SDA changes only after scl_fall, never while SCL high.
- Simultaneous scl edge and START/STOP in the same clk: START/STOP wins.
- Reset mid-transfer releases SDA/SCL immediately.

Optional Feature:
- Macro: I2C_TARGET_CLK_STRETCH_EN.
- Defined: in TX_LOAD with tx_valid=0, after scl_fall assert scl_oe=1 until tx_valid rises. Then latch the byte, release SCL one clk later, and continue.
- Not defined: scl_oe tied 0 and the 0xFF fallback applies.

Decomposition:
- Shared package i2c_pkg holds:
  - state enum (typedef i2c_target_state_t);
  - ACK=1'b0, NACK=1'b1;
  - default address constant.
- One sub-module, i2c_line_sync: synchronizer plus edge/START/STOP detector, instantiated once for the SCL/SDA pair.

Test Plan:
- Master writes addr 0x50 W, data 0xA5, 0x3C, STOP -> ACK at the 9th clock each time; rx_valid pulses twice with rx_data 0xA5 then 0x3C; addr_hit falls at STOP.
- Master sends addr 0x51 W -> no ACK (SDA stays high); no rx_valid; state IGNORE until STOP.
- Master reads addr 0x50 R with tx_data 0x96 valid, master ACKs then NACKs -> two bytes 0x96 on SDA MSB first; tx_ready pulses twice; release after NACK.
- Repeated START after a write byte, then addr 0x50 R -> rw=1, address re-ACKed, no STOP needed.
- resetN low mid-RX_BYTE -> sda_oe=0 and all outputs 0 asynchronously; next START is decoded normally.
- With CLK_STRETCH_EN, read with tx_valid low for 50 clk -> scl_oe=1 for that period; byte sent correctly after tx_valid.
